pump_plc_ctrl: RTL and testbench
================================

// Module: pump_plc_ctrl
// PURPOSE
//  Parametrised tank-level PLC core, successor to the fixed 2-pump controller under Top_Pump_Plc.
//  - Samples water_lvl on a divided tick.
//  - Drives Low/Mid/High flags and an 8-segment level bar.
//  - Runs a lead/lag state machine over NUM_PUMPS pumps, rotating the lead pump after each fill.
//  - Optional plausibility guard trips on sensor data that looks tampered with.
// PARAMETERS
//  LVL_W     8       level width (>=3)
//  NUM_PUMPS 2       pump count (>=2)
//  LOW_TH    64      fill starts below this level
//  HIGH_TH   192     fill stops at or above this level (must satisfy HIGH_TH > LOW_TH)
//  CRIT_TH   32      below this level, all pumps run (must satisfy CRIT_TH <= LOW_TH)
//  TICK_DIV  100000  clocks per sample tick (>=2)
//  MIN_ON    16      minimum ticks spent in a fill state before stopping
//  MAX_STEP  8       guard: maximum allowed |delta level| per tick
// PORTS
//  CLK100MHZ            in   1                     system clock
//  rst_n                in   1                     async active-low reset
//  enable               in   1                     run permit
//  water_lvl            in   LVL_W                 tank level, unsigned
//  water_trend          in   1                     1 = level rising
//  Low                  out  1                     level < LOW_TH
//  Mid                  out  1                     LOW_TH <= level < HIGH_TH
//  High                 out  1                     level >= HIGH_TH
//  water_lvl_indicator  out  8                     thermometer bar
//  pump_ctrl            out  NUM_PUMPS             bit i = pump i on
//  lead_idx             out  $clog2(NUM_PUMPS)     current lead pump
//  state                out  2                     00 IDLE, 01 FILL_LEAD, 10 FILL_ALL, 11 FAULT
//  fault                out  1                     guard trip, sticky
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n).
//  - Reset values:
//    - all outputs 0; state = IDLE; lead_idx = 0.
//    - tick counter, run counter, lvl_q and sample-valid flag cleared.
//    - Holds mid-fill as well: pumps drop on the rst_n falling edge, no clock needed.
//  - Tick counter:
//    - counts 0..TICK_DIV-1, then wraps to 0.
//    - tick = 1 for one clock when count == TICK_DIV-1.
//  - At each tick edge:
//    - lvl_q <= water_lvl.
//    - Low/Mid/High are registered from water_lvl; exactly one is set after the first tick.
//    - Bar: seg = water_lvl >> (LVL_W-3) (range 0..7); bit i = (seg >= i).
//  - Run counter:
//    - increments on each tick while in FILL_LEAD or FILL_ALL; saturates at MIN_ON.
//    - cleared on entry to IDLE.
//  - Escalation FILL_LEAD -> FILL_ALL does not restart the run counter.
//  - FSM transitions are evaluated on the tick edge unless noted. Priority, highest first:
//    1. enable == 0: go to IDLE on the next clock edge (does not wait for tick). No lead rotation. Not applied in FAULT.
//    2. Guard trip: go to FAULT (only with the CONFIGURATION macro).
//    3. FILL_* with water_lvl >= HIGH_TH and run == MIN_ON:
//       - go to IDLE;
//       - lead_idx <= (lead_idx == NUM_PUMPS-1) ? 0 : lead_idx + 1.
//    4. IDLE with water_lvl < LOW_TH:
//       - go to FILL_ALL if water_lvl < CRIT_TH, else FILL_LEAD.
//    5. FILL_LEAD with (water_lvl < CRIT_TH) or (run == MIN_ON and water_trend == 0): go to FILL_ALL.
//  - Reaching HIGH_TH before MIN_ON ticks: keep filling until run == MIN_ON.
//  - Between LOW_TH and HIGH_TH the state holds (hysteresis band).
//  - pump_ctrl is registered from the next state, so it changes on the same edge as state:
//    - IDLE: 0
//    - FILL_LEAD: one-hot at lead_idx
//    - FILL_ALL: all ones
//    - FAULT: 0
// CONFIGURATION
//  PUMP_PLC_TROJAN_GUARD_EN defined:
//   - On each tick where the sample-valid flag is set: trip if |water_lvl - lvl_q| > MAX_STEP.
//   - The valid flag is set on the first tick after reset, so the first sample is never checked.
//   - On trip: fault <= 1, state = FAULT, pumps off.
//   - FAULT is left only by rst_n; enable is ignored while in FAULT.
//  PUMP_PLC_TROJAN_GUARD_EN undefined:
//   - No guard logic; fault is tied to 0; FAULT is unreachable; MAX_STEP is unused.
// TESTING  (defaults except TICK_DIV = 4)
//  1. enable = 1, lvl = 50 -> first tick edge: state FILL_LEAD, pump_ctrl = 01, Low = 1.
//     Then lvl = 200 with run == 16 -> pump_ctrl = 00, lead_idx = 1.
//     Then lvl = 50 -> pump_ctrl = 10.
//  2. IDLE, lvl = 20 -> FILL_ALL, pump_ctrl = 11.
//     In FILL_LEAD: trend = 0 at run == 16 -> FILL_ALL, pump_ctrl = 11.
//  3. Filling, lvl = 200 reached at run == 5 -> pumps stay on until run == 16, then 00.
//     lvl = 0xA0 -> water_lvl_indicator = 0011_1111.
//  4. rst_n = 0 in FILL_ALL between ticks -> pump_ctrl = 00, state = 00, lead_idx = 0, flags = 0, bar = 0,
//     all with no clock edge.
//     enable = 0 in FILL_LEAD -> IDLE on the next clock; lead_idx unchanged.
//  5. Guard enabled: lvl 100 -> 130 across one tick -> fault = 1, pumps 00, state 11;
//     lvl back to 50 -> still FAULT.
//     Guard disabled: same stimulus -> fault = 0, normal FSM behaviour.
//  6. NUM_PUMPS = 3: three consecutive complete fills -> lead_idx 0 -> 1 -> 2 -> 0;
//     FILL_LEAD pump_ctrl = 001, 010, 100 respectively.

Source files
------------

// File: rtl/pump_plc_ctrl_if.sv
// Bus bundle for pump_plc_ctrl: run permit and level sensor in, flags, bar and pump drive out.
// LVL_W and NUM_PUMPS must match the parameters of the attached pump_plc_ctrl.
interface pump_plc_ctrl_if #(
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned NUM_PUMPS = 2
);
  localparam int unsigned LEAD_W = $clog2(NUM_PUMPS);

  logic                 enable;
  logic [LVL_W-1:0]     water_lvl;
  logic                 water_trend;
  logic                 Low;
  logic                 Mid;
  logic                 High;
  logic [7:0]           water_lvl_indicator;
  logic [NUM_PUMPS-1:0] pump_ctrl;
  logic [LEAD_W-1:0]    lead_idx;
  logic [1:0]           state;
  logic                 fault;

  // Supervisory side: drives the permit and sensor, observes the controller.
  modport master (
    output enable, water_lvl, water_trend,
    input  Low, Mid, High, water_lvl_indicator, pump_ctrl, lead_idx, state, fault
  );

  // Controller side.
  modport slave (
    input  enable, water_lvl, water_trend,
    output Low, Mid, High, water_lvl_indicator, pump_ctrl, lead_idx, state, fault
  );
endinterface

// File: rtl/pump_plc_ctrl.sv
// Tank-level PLC core: ticked level sampling, Low/Mid/High flags, 8-segment bar and a
// lead/lag fill FSM over NUM_PUMPS pumps with lead rotation after every completed fill.
// Optional sensor plausibility guard enabled by defining PUMP_PLC_TROJAN_GUARD_EN.
module pump_plc_ctrl #(
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned NUM_PUMPS = 2,
  parameter int unsigned LOW_TH    = 64,
  parameter int unsigned HIGH_TH   = 192,
  parameter int unsigned CRIT_TH   = 32,
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned MIN_ON    = 16,
  parameter int unsigned MAX_STEP  = 8
) (
  input  logic           CLK100MHZ,
  input  logic           rst_n,
  pump_plc_ctrl_if.slave bus
);
  localparam int unsigned LEAD_W = $clog2(NUM_PUMPS);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned RUN_W  = (MIN_ON < 1) ? 1 : $clog2(MIN_ON + 1);

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_FILL_LEAD = 2'b01;
  localparam logic [1:0] ST_FILL_ALL  = 2'b10;
  localparam logic [1:0] ST_FAULT     = 2'b11;

  localparam logic [LVL_W-1:0]  LOW_V     = LVL_W'(LOW_TH);
  localparam logic [LVL_W-1:0]  HIGH_V    = LVL_W'(HIGH_TH);
  localparam logic [LVL_W-1:0]  CRIT_V    = LVL_W'(CRIT_TH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MIN_ON);
  localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(NUM_PUMPS - 1);

  logic [TICK_W-1:0]    tick_cnt_q;
  logic                 tick_c;
  logic [1:0]           state_q, state_d;
  logic [LEAD_W-1:0]    lead_q, lead_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [NUM_PUMPS-1:0] pump_q, pump_d;
  logic                 low_q, mid_q, high_q;
  logic [7:0]           bar_q, bar_c;
  logic [2:0]           seg_c;
  logic                 lvl_low_c, lvl_high_c, lvl_crit_c, run_done_c;
  logic                 trip_c;

  assign tick_c     = (tick_cnt_q == TICK_LAST);
  assign lvl_low_c  = (bus.water_lvl < LOW_V);
  assign lvl_high_c = (bus.water_lvl >= HIGH_V);
  assign lvl_crit_c = (bus.water_lvl < CRIT_V);
  assign run_done_c = (run_q == RUN_MAX);
  assign seg_c      = bus.water_lvl[LVL_W-1 -: 3];

  // Free-running sample tick divider.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n)      tick_cnt_q <= '0;
    else if (tick_c) tick_cnt_q <= '0;
    else             tick_cnt_q <= tick_cnt_q + TICK_W'(1);
  end

  // Thermometer bar from the top three level bits.
  always_comb begin
    bar_c = '0;
    for (int i = 0; i < 8; i++) bar_c[i] = (seg_c >= 3'(i));
  end

`ifdef PUMP_PLC_TROJAN_GUARD_EN
  localparam logic [LVL_W-1:0] STEP_V = LVL_W'(MAX_STEP);

  logic [LVL_W-1:0] lvl_q;
  logic [LVL_W-1:0] delta_c;
  logic             valid_q;
  logic             fault_q;

  assign delta_c = (bus.water_lvl >= lvl_q) ? (bus.water_lvl - lvl_q) : (lvl_q - bus.water_lvl);
  assign trip_c  = tick_c && valid_q && (delta_c > STEP_V);
  assign bus.fault = fault_q;

  // Previous sample for the step check; the first sample after reset is only captured.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (tick_c) begin
        lvl_q   <= bus.water_lvl;
        valid_q <= 1'b1;
      end
      fault_q <= (state_d == ST_FAULT);
    end
  end
`else
  logic [LVL_W-1:0] max_step_unused_c;

  assign max_step_unused_c = LVL_W'(MAX_STEP);
  assign trip_c            = 1'b0;
  assign bus.fault         = 1'b0;
`endif

  // Next-state, lead rotation, run counter and pump drive.
  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    run_d   = run_q;
    pump_d  = '0;

    if ((state_q != ST_FAULT) && !bus.enable) begin
      state_d = ST_IDLE;
    end else if (tick_c) begin
      if (trip_c) begin
        state_d = ST_FAULT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (lvl_low_c) state_d = lvl_crit_c ? ST_FILL_ALL : ST_FILL_LEAD;
          end
          ST_FILL_LEAD, ST_FILL_ALL: begin
            if (lvl_high_c && run_done_c) begin
              state_d = ST_IDLE;
              lead_d  = (lead_q == LEAD_LAST) ? '0 : lead_q + LEAD_W'(1);
            end else if ((state_q == ST_FILL_LEAD) &&
                         (lvl_crit_c || (run_done_c && !bus.water_trend))) begin
              state_d = ST_FILL_ALL;
            end
          end
          default: ;
        endcase
      end
    end

    if (state_d == ST_IDLE) begin
      run_d = '0;
    end else if (tick_c && ((state_q == ST_FILL_LEAD) || (state_q == ST_FILL_ALL)) && !run_done_c) begin
      run_d = run_q + RUN_W'(1);
    end

    case (state_d)
      ST_FILL_LEAD: pump_d = NUM_PUMPS'(1) << lead_d;
      ST_FILL_ALL:  pump_d = '1;
      default:      pump_d = '0;
    endcase
  end

  // FSM, lead, run counter and pump registers.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lead_q  <= '0;
      run_q   <= '0;
      pump_q  <= '0;
    end else begin
      state_q <= state_d;
      lead_q  <= lead_d;
      run_q   <= run_d;
      pump_q  <= pump_d;
    end
  end

  // Level flags and bar, refreshed once per tick.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      low_q  <= 1'b0;
      mid_q  <= 1'b0;
      high_q <= 1'b0;
      bar_q  <= '0;
    end else if (tick_c) begin
      low_q  <= lvl_low_c;
      mid_q  <= !lvl_low_c && !lvl_high_c;
      high_q <= lvl_high_c;
      bar_q  <= bar_c;
    end
  end

  assign bus.Low                 = low_q;
  assign bus.Mid                 = mid_q;
  assign bus.High                = high_q;
  assign bus.water_lvl_indicator = bar_q;
  assign bus.pump_ctrl           = pump_q;
  assign bus.lead_idx            = lead_q;
  assign bus.state               = state_q;
endmodule

// File: tb/tb_pump_plc_ctrl.sv
// Bench for pump_plc_ctrl: vector table through a scoreboard queue on a 2-pump instance,
// hand-written enable/async-reset sequence, and lead rotation on a 3-pump instance.
// Follows PUMP_PLC_TROJAN_GUARD_EN to pick the matching vector table.
module tb_pump_plc_ctrl;
  localparam int unsigned TDIV = 4;

  typedef struct {
    logic       en;
    logic [7:0] lvl;
    logic       trend;
    int         ticks;
    logic [1:0] st;
    logic [1:0] pump;
    logic       lead;
    logic [2:0] lmh;
    logic [7:0] bar;
    logic       flt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  pump_plc_ctrl_if #(.LVL_W(8), .NUM_PUMPS(2)) bus2 ();
  pump_plc_ctrl_if #(.LVL_W(8), .NUM_PUMPS(3)) bus3 ();

  pump_plc_ctrl #(.NUM_PUMPS(2), .TICK_DIV(TDIV)) dut2 (
    .CLK100MHZ(clk), .rst_n(rst_n), .bus(bus2.slave)
  );
  pump_plc_ctrl #(.NUM_PUMPS(3), .TICK_DIV(TDIV)) dut3 (
    .CLK100MHZ(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  function automatic vec_t mk(input logic en, input logic [7:0] lvl, input logic trend, input int ticks,
                              input logic [1:0] st, input logic [1:0] pump, input logic lead,
                              input logic [2:0] lmh, input logic [7:0] bar, input logic flt);
    vec_t v;
    v.en = en; v.lvl = lvl; v.trend = trend; v.ticks = ticks;
    v.st = st; v.pump = pump; v.lead = lead; v.lmh = lmh; v.bar = bar; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic tick_edges(input int n);
    int seen = 0;
    while (seen < n) begin
      clk_edge();
      if (edge_cnt % TDIV == 0) seen++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus2.enable = 1'b0; bus2.water_lvl = '0; bus2.water_trend = 1'b1;
    bus3.enable = 1'b0; bus3.water_lvl = '0; bus3.water_trend = 1'b1;
    clk_edge();
    clk_edge();
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic chk2(input string tag, input logic [1:0] st, input logic [1:0] pump, input logic lead,
                      input logic [2:0] lmh, input logic [7:0] bar, input logic flt);
    chk({tag, " state"}, 32'(bus2.state), 32'(st));
    chk({tag, " pump"},  32'(bus2.pump_ctrl), 32'(pump));
    chk({tag, " lead"},  32'(bus2.lead_idx), 32'(lead));
    chk({tag, " lmh"},   32'({bus2.Low, bus2.Mid, bus2.High}), 32'(lmh));
    chk({tag, " bar"},   32'(bus2.water_lvl_indicator), 32'(bar));
    chk({tag, " fault"}, 32'(bus2.fault), 32'(flt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   lvl;

`ifdef PUMP_PLC_TROJAN_GUARD_EN
    tbl.push_back(mk(1'b1, 8'd100, 1'b1, 1, 2'b00, 2'b00, 1'b0, 3'b010, 8'h0F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd104, 1'b1, 1, 2'b00, 2'b00, 1'b0, 3'b010, 8'h0F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd130, 1'b1, 1, 2'b11, 2'b00, 1'b0, 3'b010, 8'h1F, 1'b1));
    tbl.push_back(mk(1'b1, 8'd50,  1'b1, 1, 2'b11, 2'b00, 1'b0, 3'b100, 8'h03, 1'b1));
    tbl.push_back(mk(1'b0, 8'd50,  1'b1, 1, 2'b11, 2'b00, 1'b0, 3'b100, 8'h03, 1'b1));
`else
    tbl.push_back(mk(1'b1, 8'd50,  1'b1, 1,  2'b01, 2'b01, 1'b0, 3'b100, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 8'd50,  1'b1, 16, 2'b01, 2'b01, 1'b0, 3'b100, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 8'd200, 1'b1, 1,  2'b00, 2'b00, 1'b1, 3'b001, 8'h7F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd50,  1'b1, 1,  2'b01, 2'b10, 1'b1, 3'b100, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 8'd50,  1'b0, 16, 2'b01, 2'b10, 1'b1, 3'b100, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 8'd50,  1'b0, 1,  2'b10, 2'b11, 1'b1, 3'b100, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 8'd200, 1'b1, 1,  2'b00, 2'b00, 1'b0, 3'b001, 8'h7F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd20,  1'b1, 1,  2'b10, 2'b11, 1'b0, 3'b100, 8'h01, 1'b0));
    tbl.push_back(mk(1'b1, 8'd20,  1'b1, 5,  2'b10, 2'b11, 1'b0, 3'b100, 8'h01, 1'b0));
    tbl.push_back(mk(1'b1, 8'd200, 1'b1, 1,  2'b10, 2'b11, 1'b0, 3'b001, 8'h7F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd200, 1'b1, 10, 2'b10, 2'b11, 1'b0, 3'b001, 8'h7F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd200, 1'b1, 1,  2'b00, 2'b00, 1'b1, 3'b001, 8'h7F, 1'b0));
    tbl.push_back(mk(1'b1, 8'hA0,  1'b1, 1,  2'b00, 2'b00, 1'b1, 3'b010, 8'h3F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd100, 1'b1, 1,  2'b00, 2'b00, 1'b1, 3'b010, 8'h0F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd130, 1'b1, 1,  2'b00, 2'b00, 1'b1, 3'b010, 8'h1F, 1'b0));
    tbl.push_back(mk(1'b1, 8'd50,  1'b1, 1,  2'b01, 2'b10, 1'b1, 3'b100, 8'h03, 1'b0));
`endif

    // Reset values on both instances while rst_n is held low.
    rst_n = 1'b0;
    bus2.enable = 1'b0; bus2.water_lvl = '0; bus2.water_trend = 1'b1;
    bus3.enable = 1'b0; bus3.water_lvl = '0; bus3.water_trend = 1'b1;
    clk_edge();
    chk2("reset", 2'b00, 2'b00, 1'b0, 3'b000, 8'h00, 1'b0);
    chk("reset pump3",  32'(bus3.pump_ctrl), 32'd0);
    chk("reset state3", 32'(bus3.state), 32'd0);
    chk("reset lead3",  32'(bus3.lead_idx), 32'd0);
    do_reset();

    // Vector table through the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      sb.push_back(tbl[i]);
      bus2.enable      = tbl[i].en;
      bus2.water_lvl   = tbl[i].lvl;
      bus2.water_trend = tbl[i].trend;
      tick_edges(tbl[i].ticks);
      e = sb.pop_front();
      chk2($sformatf("row%0d", i), e.st, e.pump, e.lead, e.lmh, e.bar, e.flt);
    end

    // enable drop is immediate; async reset mid-fill drops everything with no clock.
    do_reset();
    bus2.enable = 1'b1; bus2.water_lvl = 8'd50; bus2.water_trend = 1'b1;
    tick_edges(1);
    chk("seqA fill state", 32'(bus2.state), 32'd1);
    chk("seqA fill pump",  32'(bus2.pump_ctrl), 32'd1);
    bus2.enable = 1'b0;
    clk_edge();
    chk("seqA dis state", 32'(bus2.state), 32'd0);
    chk("seqA dis pump",  32'(bus2.pump_ctrl), 32'd0);
    chk("seqA dis lead",  32'(bus2.lead_idx), 32'd0);
    bus2.enable = 1'b1;
    tick_edges(1);
    chk("seqA refill state", 32'(bus2.state), 32'd1);
    bus2.water_lvl = 8'd44; tick_edges(1);
    bus2.water_lvl = 8'd38; tick_edges(1);
    chk("seqA 38 state", 32'(bus2.state), 32'd1);
    bus2.water_lvl = 8'd31; tick_edges(1);
    chk("seqA crit state", 32'(bus2.state), 32'd2);
    chk("seqA crit pump",  32'(bus2.pump_ctrl), 32'd3);
    clk_edge();
    clk_edge();
    #2;
    rst_n = 1'b0;
    #1;
    chk2("asyncrst", 2'b00, 2'b00, 1'b0, 3'b000, 8'h00, 1'b0);

    // Three complete fills on the 3-pump instance with gentle level ramps.
    do_reset();
    bus3.enable = 1'b1; bus3.water_trend = 1'b1; bus3.water_lvl = 8'd64;
    tick_edges(1);
    chk("p3 idle state", 32'(bus3.state), 32'd0);
    for (int f = 0; f < 3; f++) begin
      bus3.water_lvl = 8'd56;
      tick_edges(1);
      chk($sformatf("p3 fill%0d state", f), 32'(bus3.state), 32'd1);
      chk($sformatf("p3 fill%0d pump", f),  32'(bus3.pump_ctrl), 32'(3'b001 << f));
      chk($sformatf("p3 fill%0d lead", f),  32'(bus3.lead_idx), 32'(f));
      for (int k = 1; k <= 17; k++) begin
        lvl = 56 + 8 * k;
        bus3.water_lvl = 8'(lvl);
        tick_edges(1);
        if (k == 16) chk($sformatf("p3 fill%0d hold", f), 32'(bus3.state), 32'd1);
      end
      chk($sformatf("p3 done%0d state", f), 32'(bus3.state), 32'd0);
      chk($sformatf("p3 done%0d pump", f),  32'(bus3.pump_ctrl), 32'd0);
      chk($sformatf("p3 done%0d lead", f),  32'(bus3.lead_idx), 32'((f + 1) % 3));
      for (int k = 1; k <= 16; k++) begin
        lvl = 192 - 8 * k;
        bus3.water_lvl = 8'(lvl);
        tick_edges(1);
      end
      chk($sformatf("p3 band%0d state", f), 32'(bus3.state), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
